// File: rtl/dmem_port_pkg.sv
// Shared types and constants for the pipeline-to-dmem request port.
// Holds the FSM state encoding, access size codes and the alignment rule.
package dmem_port_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RMW_WR,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int DEF_TIMEOUT = 255;

    // Size code 3 has no meaning on this bus, so it is rejected like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Little-endian lane handling: pulls a sign/zero-extended value out of a read word,
// and merges sub-word store data into a read word for read-modify-write.
module dmem_align
    import dmem_port_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = word[7:0];
        half_sel   = addr_lo[1] ? word[31:16] : word[15:0];
        load_data  = word;
        merge_data = word;

        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase

        case (size)
            SZ_B: begin
                load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                case (addr_lo)
                    2'd0:    merge_data[7:0]   = wdata[7:0];
                    2'd1:    merge_data[15:8]  = wdata[7:0];
                    2'd2:    merge_data[23:16] = wdata[7:0];
                    default: merge_data[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: begin
                load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                if (addr_lo[1])
                    merge_data[31:16] = wdata[15:0];
                else
                    merge_data[15:0] = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_req_port.sv
// Single-outstanding data-memory port: turns byte/half/word pipeline ops into
// word-wide dmem transactions, using read-modify-write for sub-word stores.
module dmem_req_port
    import dmem_port_pkg::*;
#(
    parameter int TAG_W   = 6,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_data,
    output logic             resp_err,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic             dmem_req_we,
    output logic [31:0]      dmem_req_addr,
    output logic [31:0]      dmem_req_data,
    input  logic             dmem_resp_valid,
    input  logic [31:0]      dmem_resp_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    logic               op_we;
    logic [1:0]         op_size;
    logic               op_unsigned;
    logic [31:0]        op_addr;
    logic [31:0]        op_wdata;
    logic [TAG_W-1:0]   op_tag;
    logic [CNT_W-1:0]   wait_cnt;
    logic [31:0]        load_data;
    logic [31:0]        merge_data;

    assign req_ready = (state == IDLE);

    dmem_align u_align (
        .size        (op_size),
        .is_unsigned (op_unsigned),
        .addr_lo     (op_addr[1:0]),
        .word        (dmem_resp_data),
        .wdata       (op_wdata),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // Outputs are loaded on the transition into the state that owns them and
    // cleared when leaving it, so the dmem bus reads all-zero while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_data      <= '0;
            resp_tag       <= '0;
            dmem_req_valid <= 1'b0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_data  <= '0;
            wait_cnt       <= '0;
            op_we          <= 1'b0;
            op_size        <= SZ_B;
            op_unsigned    <= 1'b0;
            op_addr        <= '0;
            op_wdata       <= '0;
            op_tag         <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_we       <= req_we;
                        op_size     <= req_size;
                        op_unsigned <= req_unsigned;
                        op_addr     <= req_addr;
                        op_wdata    <= req_wdata;
                        op_tag      <= req_tag;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_tag   <= req_tag;
                        end else begin
                            state          <= ISSUE;
                            dmem_req_valid <= 1'b1;
                            dmem_req_addr  <= {req_addr[31:2], 2'b00};
                            if (req_we && req_size == SZ_W) begin
                                dmem_req_we   <= 1'b1;
                                dmem_req_data <= req_wdata;
                            end
                        end
                    end
                end

                ISSUE: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        dmem_req_we    <= 1'b0;
                        dmem_req_addr  <= '0;
                        dmem_req_data  <= '0;
                        if (op_we && op_size == SZ_W) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_tag   <= op_tag;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end

                // Sub-word stores reuse the read data here to build the merged write word.
                WAIT: begin
                    if (dmem_resp_valid) begin
                        if (op_we) begin
                            state          <= RMW_WR;
                            dmem_req_valid <= 1'b1;
                            dmem_req_we    <= 1'b1;
                            dmem_req_addr  <= {op_addr[31:2], 2'b00};
                            dmem_req_data  <= merge_data;
                        end else begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_tag   <= op_tag;
                            resp_data  <= load_data;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wait_cnt == CNT_LAST) begin
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_tag   <= op_tag;
                        end
                    end
                end

                RMW_WR: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        dmem_req_we    <= 1'b0;
                        dmem_req_addr  <= '0;
                        dmem_req_data  <= '0;
                        state          <= DONE;
                        resp_valid     <= 1'b1;
                        resp_tag       <= op_tag;
                    end
                end

                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_req_port.sv
// Directed bench for dmem_req_port: a table of ops with hand-computed results run
// against a 2-cycle-latency memory model, plus reset, stray-response and timeout cases.
module tb_dmem_req_port;
    import dmem_port_pkg::*;

    localparam int TAG_W   = 6;
    localparam int TIMEOUT = 255;
    localparam int NV      = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we = 1'b0;
    logic [1:0]       req_size = 2'd0;
    logic             req_unsigned = 1'b0;
    logic [31:0]      req_addr = '0;
    logic [31:0]      req_wdata = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             resp_valid;
    logic [TAG_W-1:0] resp_tag;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic             dmem_req_valid;
    logic             dmem_req_ready;
    logic             dmem_req_we;
    logic [31:0]      dmem_req_addr;
    logic [31:0]      dmem_req_data;
    logic             dmem_resp_valid;
    logic [31:0]      dmem_resp_data;

    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    dmem_req_port #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_tag         (req_tag),
        .resp_valid      (resp_valid),
        .resp_tag        (resp_tag),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_data   (dmem_req_data),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_data  (dmem_resp_data)
    );

    // Memory model: always ready, read data returned two cycles after the read handshake.
    logic [31:0] mem [0:2047];
    logic        p1_valid = 1'b0;
    logic [31:0] p1_addr = '0;
    logic        pipe_valid = 1'b0;
    logic [31:0] pipe_data = '0;
    logic        withhold = 1'b0;
    logic        stray_valid = 1'b0;
    logic [31:0] stray_data = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic        tohost_pass = 1'b0;

    assign dmem_req_ready  = 1'b1;
    assign dmem_resp_valid = pipe_valid | stray_valid;
    assign dmem_resp_data  = stray_valid ? stray_data : pipe_data;

    always @(posedge clk) begin
        pipe_valid <= p1_valid & ~withhold;
        pipe_data  <= mem[p1_addr[12:2]];
        p1_valid   <= (dmem_req_valid === 1'b1) && (dmem_req_we === 1'b0);
        p1_addr    <= dmem_req_addr;
        if (dmem_req_valid === 1'b1) begin
            if (dmem_req_we) begin
                mem[dmem_req_addr[12:2]] = dmem_req_data;
                wr_cnt       = wr_cnt + 1;
                last_wr_addr = dmem_req_addr;
                last_wr_data = dmem_req_data;
                if (dmem_req_addr == 32'h0000_1000 && dmem_req_data == 32'd1)
                    tohost_pass = 1'b1;
            end else begin
                rd_cnt       = rd_cnt + 1;
                last_rd_addr = dmem_req_addr;
            end
        end
    end

    // Whenever no request is presented the dmem request fields must read zero.
    always @(negedge clk) begin
        if (mon_en && dmem_req_valid === 1'b0) begin
            checks++;
            if ({dmem_req_we, dmem_req_addr, dmem_req_data} !== 65'b0) begin
                failures++;
                $display("[TB] FAIL idle_dmem_zero: got we=%b addr=0x%08h data=0x%08h expected all zero",
                         dmem_req_we, dmem_req_addr, dmem_req_data);
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  tag;
        logic        hold;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [5:0] tag, input logic hold,
                                input logic [31:0] exp_data, input logic exp_err,
                                input int exp_lat, input int exp_rd, input int exp_wr,
                                input logic [31:0] exp_wdata);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.tag = tag; v.hold = hold; v.exp_data = exp_data; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic startOp(input vec_t v);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_tag      = v.tag;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Latency counts cycles from the accept cycle to the cycle showing resp_valid.
    task automatic applyStimulus(input vec_t v, input int idx);
        int               rd0;
        int               wr0;
        int               lat;
        bit               seen;
        logic [31:0]      got_data;
        logic [TAG_W-1:0] got_tag;
        logic             got_err;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        seen = 1'b0;
        got_data = '0;
        got_tag = '0;
        got_err = 1'b0;
        withhold = v.hold;
        startOp(v);
        lat = 1;
        while (!seen && lat <= 400) begin
            if (resp_valid === 1'b1) begin
                seen     = 1'b1;
                got_data = resp_data;
                got_tag  = resp_tag;
                got_err  = resp_err;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        withhold = 1'b0;
        checkOutput($sformatf("v%0d_resp_seen", idx), {31'b0, seen}, 32'd1);
        checkOutput($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        checkOutput($sformatf("v%0d_data", idx), got_data, v.exp_data);
        checkOutput($sformatf("v%0d_tag", idx), {26'b0, got_tag}, {26'b0, v.tag});
        checkOutput($sformatf("v%0d_err", idx), {31'b0, got_err}, {31'b0, v.exp_err});
        checkOutput($sformatf("v%0d_reads", idx), 32'(rd_cnt - rd0), 32'(v.exp_rd));
        checkOutput($sformatf("v%0d_writes", idx), 32'(wr_cnt - wr0), 32'(v.exp_wr));
        if (v.exp_rd > 0)
            checkOutput($sformatf("v%0d_rd_addr", idx), last_rd_addr, {v.addr[31:2], 2'b00});
        if (v.exp_wr > 0) begin
            checkOutput($sformatf("v%0d_wr_addr", idx), last_wr_addr, {v.addr[31:2], 2'b00});
            checkOutput($sformatf("v%0d_wr_data", idx), last_wr_data, v.exp_wdata);
        end
        @(negedge clk);
        checkOutput($sformatf("v%0d_resp_one_cycle", idx), {31'b0, resp_valid}, 32'd0);
        checkOutput($sformatf("v%0d_ready_after", idx), {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int wr_before;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem['h40] = 32'h8077_F0A5;

        //               we    size uns  addr           wdata          tag  hold exp_data      err lat rd wr exp_wdata
        vecs[0]  = mk(1'b0, SZ_W, 1'b0, 32'h0000_0100, 32'h0,         6'd5,  1'b0, 32'h8077_F0A5, 1'b0, 4, 1, 0, 32'h0);
        vecs[1]  = mk(1'b0, SZ_B, 1'b0, 32'h0000_0100, 32'h0,         6'd1,  1'b0, 32'hFFFF_FFA5, 1'b0, 4, 1, 0, 32'h0);
        vecs[2]  = mk(1'b0, SZ_B, 1'b1, 32'h0000_0101, 32'h0,         6'd2,  1'b0, 32'h0000_00F0, 1'b0, 4, 1, 0, 32'h0);
        vecs[3]  = mk(1'b0, SZ_H, 1'b0, 32'h0000_0102, 32'h0,         6'd3,  1'b0, 32'hFFFF_8077, 1'b0, 4, 1, 0, 32'h0);
        vecs[4]  = mk(1'b0, SZ_H, 1'b1, 32'h0000_0102, 32'h0,         6'd4,  1'b0, 32'h0000_8077, 1'b0, 4, 1, 0, 32'h0);
        vecs[5]  = mk(1'b1, SZ_B, 1'b0, 32'h0000_0103, 32'h12,        6'd6,  1'b0, 32'h0,         1'b0, 5, 1, 1, 32'h1277_F0A5);
        vecs[6]  = mk(1'b0, SZ_W, 1'b0, 32'h0000_0100, 32'h0,         6'd7,  1'b0, 32'h1277_F0A5, 1'b0, 4, 1, 0, 32'h0);
        vecs[7]  = mk(1'b1, SZ_W, 1'b0, 32'h0000_1000, 32'h1,         6'd8,  1'b0, 32'h0,         1'b0, 2, 0, 1, 32'h1);
        vecs[8]  = mk(1'b0, SZ_H, 1'b0, 32'h0000_0101, 32'h0,         6'd9,  1'b0, 32'h0,         1'b1, 1, 0, 0, 32'h0);
        vecs[9]  = mk(1'b0, SZ_W, 1'b0, 32'h0000_0102, 32'h0,         6'd10, 1'b0, 32'h0,         1'b1, 1, 0, 0, 32'h0);
        vecs[10] = mk(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,         6'd11, 1'b0, 32'h0,         1'b1, 1, 0, 0, 32'h0);
        vecs[11] = mk(1'b1, SZ_H, 1'b0, 32'h0000_0102, 32'hBEEF,      6'd12, 1'b0, 32'h0,         1'b0, 5, 1, 1, 32'hBEEF_F0A5);
        vecs[12] = mk(1'b0, SZ_B, 1'b0, 32'h0000_0103, 32'h0,         6'd13, 1'b0, 32'hFFFF_FFBE, 1'b0, 4, 1, 0, 32'h0);
        vecs[13] = mk(1'b1, SZ_H, 1'b0, 32'h0000_0100, 32'hFFFF_1234, 6'd14, 1'b0, 32'h0,         1'b0, 5, 1, 1, 32'hBEEF_1234);
        vecs[14] = mk(1'b1, SZ_B, 1'b0, 32'h0000_0101, 32'h5A,        6'd15, 1'b0, 32'h0,         1'b0, 5, 1, 1, 32'hBEEF_5A34);
        vecs[15] = mk(1'b0, SZ_H, 1'b0, 32'h0000_0100, 32'h0,         6'd16, 1'b0, 32'h0000_5A34, 1'b0, 4, 1, 0, 32'h0);
        vecs[16] = mk(1'b0, SZ_B, 1'b1, 32'h0000_0102, 32'h0,         6'd63, 1'b0, 32'h0000_00EF, 1'b0, 4, 1, 0, 32'h0);
        vecs[17] = mk(1'b1, SZ_W, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 6'd17, 1'b0, 32'h0,         1'b0, 2, 0, 1, 32'hCAFE_F00D);
        vecs[18] = mk(1'b0, SZ_W, 1'b0, 32'h0000_0104, 32'h0,         6'd18, 1'b0, 32'hCAFE_F00D, 1'b0, 4, 1, 0, 32'h0);
        vecs[19] = mk(1'b1, SZ_H, 1'b0, 32'h0000_0103, 32'h7777,      6'd22, 1'b0, 32'h0,         1'b1, 1, 0, 0, 32'h0);
        vecs[20] = mk(1'b1, SZ_W, 1'b0, 32'h0000_1002, 32'h1,         6'd23, 1'b0, 32'h0,         1'b1, 1, 0, 0, 32'h0);
        vecs[21] = mk(1'b0, SZ_W, 1'b0, 32'h0000_0100, 32'h0,         6'd19, 1'b1, 32'h0,         1'b1, TIMEOUT + 2, 1, 0, 32'h0);
        vecs[22] = mk(1'b1, SZ_B, 1'b0, 32'h0000_0100, 32'h99,        6'd20, 1'b1, 32'h0,         1'b1, TIMEOUT + 2, 1, 0, 32'h0);
        vecs[23] = mk(1'b0, SZ_W, 1'b0, 32'h0000_0100, 32'h0,         6'd21, 1'b0, 32'hBEEF_5A34, 1'b0, 4, 1, 0, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        checkOutput("rst_resp_tag", {26'b0, resp_tag}, 32'd0);
        checkOutput("rst_dmem_valid", {31'b0, dmem_req_valid}, 32'd0);
        checkOutput("rst_dmem_we", {31'b0, dmem_req_we}, 32'd0);
        checkOutput("rst_dmem_addr", dmem_req_addr, 32'd0);
        checkOutput("rst_dmem_data", dmem_req_data, 32'd0);
        rst_n = 1'b1;
        checkOutput("release_ready", {31'b0, req_ready}, 32'd1);
        mon_en = 1'b1;

        for (int i = 0; i < NV; i++) applyStimulus(vecs[i], i);
        checkOutput("tohost_pass", {31'b0, tohost_pass}, 32'd1);

        // Reset while the read phase of a byte store is waiting: no response, no merge write.
        wr_before = wr_cnt;
        startOp(mk(1'b1, SZ_B, 1'b0, 32'h0000_0100, 32'h77, 6'd30, 1'b0, 32'h0, 1'b0, 0, 0, 0, 32'h0));
        @(negedge clk);
        checkOutput("midop_busy", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midop_ready_after_release", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("midop_no_resp_%0d", i), {31'b0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        checkOutput("midop_no_write", 32'(wr_cnt - wr_before), 32'd0);
        applyStimulus(mk(1'b0, SZ_W, 1'b0, 32'h0000_0100, 32'h0, 6'd24, 1'b0, 32'hBEEF_5A34, 1'b0, 4, 1, 0, 32'h0), 100);

        // A dmem response arriving while idle must not produce a completion.
        stray_data  = 32'hDEAD_BEEF;
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stray_no_resp_%0d", i), {31'b0, resp_valid}, 32'd0);
            checkOutput($sformatf("stray_ready_%0d", i), {31'b0, req_ready}, 32'd1);
            @(negedge clk);
        end
        applyStimulus(mk(1'b0, SZ_B, 1'b1, 32'h0000_0101, 32'h0, 6'd25, 1'b0, 32'h0000_005A, 1'b0, 4, 1, 0, 32'h0), 101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
